// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot pixel issue stage.
// Contents: the Q4.12 word format, the default frame window,
// the divergence counter width, the default drain depth and the
// issue FSM state encoding.
package mandel_pkg;

   localparam int FRAC_BITS = 12;
   localparam int WORD      = 16;
   localparam int DIV_W     = 8;

   localparam int DEF_PIPE_DEPTH = 64;

   // Default window: real axis starts at -2.0 and the imaginary axis
   // starts at +1.25, scanning top-left to bottom-right.
   localparam logic [WORD-1:0] DEF_X_START = 16'hE000;
   localparam logic [WORD-1:0] DEF_Y_START = 16'h1400;
   localparam logic [WORD-1:0] DEF_X_STEP  = 16'h0013;
   localparam logic [WORD-1:0] DEF_Y_STEP  = 16'h0015;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

endpackage

// File: rtl/mandel_raster_ctr.sv
// Column/row raster counter pair.
// Ports:
//   Clk, Reset     clock, async active-high reset
//   en             advance one pixel (caller folds in stall)
//   clr            return to pixel (0,0)
//   col, row       current pixel position
//   eol            current pixel is the last in its row
//   eof            current pixel is the last in the frame
module mandel_raster_ctr #(
   parameter int H_RES = 640,
   parameter int V_RES = 480,
   parameter int COL_W = 10,
   parameter int ROW_W = 9
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             en,
   input  logic             clr,
   output logic [COL_W-1:0] col,
   output logic [ROW_W-1:0] row,
   output logic             eol,
   output logic             eof
);

   assign eol = (col == COL_W'(H_RES - 1));
   assign eof = eol && (row == ROW_W'(V_RES - 1));

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         col <= '0;
         row <= '0;
      end else if (clr) begin
         col <= '0;
         row <= '0;
      end else if (en) begin
         if (eol) begin
            col <= '0;
            row <= row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

endmodule

// File: rtl/mandel_pixel_gen.sv
// Issue stage for the Mandelbrot divergence pipeline. Raster-scans an
// H_RES x V_RES frame, issuing one pixel (c1 + j*c2, Q4.12) per unstalled
// cycle, then PIPE_DEPTH bubbles to drain the pipe, then a frame_done pulse.
// Ports:
//   Clk, Reset            clock, async active-high reset
//   start                 begin a frame (honoured in IDLE only)
//   stall                 downstream hold; freezes state and outputs
//   x, y, div             pixel seed, always zero
//   c1, c2                complex constant of the issued pixel
//   no_op                 1 = bubble
//   pix_col, pix_row      sideband pixel position
//   busy                  frame in progress (RUN or FLUSH)
//   frame_done            one-cycle pulse at the end of FLUSH
module mandel_pixel_gen
   import mandel_pkg::*;
#(
   parameter int              H_RES      = 640,
   parameter int              V_RES      = 480,
   parameter logic [WORD-1:0] X_START    = DEF_X_START,
   parameter logic [WORD-1:0] Y_START    = DEF_Y_START,
   parameter logic [WORD-1:0] X_STEP     = DEF_X_STEP,
   parameter logic [WORD-1:0] Y_STEP     = DEF_Y_STEP,
   parameter int              PIPE_DEPTH = DEF_PIPE_DEPTH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             start,
   input  logic             stall,
   output logic [WORD-1:0]  x,
   output logic [WORD-1:0]  y,
   output logic [WORD-1:0]  c1,
   output logic [WORD-1:0]  c2,
   output logic [DIV_W-1:0] div,
   output logic             no_op,
   output logic [9:0]       pix_col,
   output logic [8:0]       pix_row,
   output logic             busy,
   output logic             frame_done
);

   localparam logic [6:0] PD = 7'(PIPE_DEPTH);

   state_t     state_q, state_d;
   logic [6:0] flush_cnt;
   logic       start_pend;
   logic       eol, eof;
   logic       go, adv, flush_end;

   // A start seen while stalled in IDLE is remembered and taken once the
   // stall drops. The frame_done cycle is excluded so a start there is lost.
   assign go        = (state_q == S_IDLE) && !stall && !frame_done && (start || start_pend);
   assign adv       = (state_q == S_RUN) && !stall;
   assign flush_end = (state_q == S_FLUSH) && !stall && (flush_cnt == PD);

   mandel_raster_ctr #(
      .H_RES (H_RES),
      .V_RES (V_RES),
      .COL_W (10),
      .ROW_W (9)
   ) u_ctr (
      .Clk   (Clk),
      .Reset (Reset),
      .en    (adv && !eof),   // position holds on the last pixel through FLUSH
      .clr   (flush_end),
      .col   (pix_col),
      .row   (pix_row),
      .eol   (eol),
      .eof   (eof)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (go)        state_d = S_RUN;
         S_RUN:   if (adv && eof) state_d = S_FLUSH;
         S_FLUSH: if (flush_end) state_d = S_IDLE;
         default:                state_d = S_IDLE;
      endcase
   end

   always_comb begin
      no_op = (state_q != S_RUN);
      busy  = (state_q != S_IDLE);
      x     = '0;
      y     = '0;
      div   = '0;
   end

   // c1/c2 accumulate in plain 16-bit two's complement; overflow wraps.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         c1         <= X_START;
         c2         <= Y_START;
         flush_cnt  <= '0;
         frame_done <= 1'b0;
         start_pend <= 1'b0;
      end else begin
         frame_done <= flush_end;
         if (go)
            start_pend <= 1'b0;
         else if ((state_q == S_IDLE) && start && stall && !frame_done)
            start_pend <= 1'b1;
         if (flush_end) begin
            c1        <= X_START;
            c2        <= Y_START;
            flush_cnt <= '0;
         end else if ((state_q == S_FLUSH) && !stall) begin
            flush_cnt <= flush_cnt + 7'd1;
         end else if (adv) begin
            if (eof)
               flush_cnt <= 7'd1;
            else if (eol) begin
               c1 <= X_START;
               c2 <= c2 - Y_STEP;
            end else
               c1 <= c1 + X_STEP;
         end
      end
   end

endmodule

// File: tb/tb_mandel_pixel_gen.sv
// Self-checking bench for mandel_pixel_gen on a 4x3 frame with a 5-deep
// drain, plus a second instance exercising c1 wrap-around.
module tb_mandel_pixel_gen;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic Reset = 1'b0, start = 1'b0, stall = 1'b0, start_w = 1'b0;

   logic [15:0] x, y, c1, c2;
   logic [7:0]  div;
   logic        no_op, busy, frame_done;
   logic [9:0]  pix_col;
   logic [8:0]  pix_row;

   logic [15:0] w_x, w_y, w_c1, w_c2;
   logic [7:0]  w_div;
   logic        w_no_op, w_busy, w_frame_done;
   logic [9:0]  w_pix_col;
   logic [8:0]  w_pix_row;

   mandel_pixel_gen #(
      .H_RES(4), .V_RES(3), .X_START(16'hE000), .Y_START(16'h1400),
      .X_STEP(16'h0100), .Y_STEP(16'h0200), .PIPE_DEPTH(5)
   ) dut (
      .Clk(Clk), .Reset(Reset), .start(start), .stall(stall),
      .x(x), .y(y), .c1(c1), .c2(c2), .div(div), .no_op(no_op),
      .pix_col(pix_col), .pix_row(pix_row), .busy(busy), .frame_done(frame_done)
   );

   mandel_pixel_gen #(
      .H_RES(4), .V_RES(3), .X_START(16'h7F00), .Y_START(16'h1400),
      .X_STEP(16'h0100), .Y_STEP(16'h0200), .PIPE_DEPTH(5)
   ) u_wrap (
      .Clk(Clk), .Reset(Reset), .start(start_w), .stall(stall),
      .x(w_x), .y(w_y), .c1(w_c1), .c2(w_c2), .div(w_div), .no_op(w_no_op),
      .pix_col(w_pix_col), .pix_row(w_pix_row), .busy(w_busy), .frame_done(w_frame_done)
   );

   typedef struct packed {
      logic [15:0] c1;
      logic [15:0] c2;
      logic [9:0]  col;
      logic [8:0]  row;
   } pix_t;

   pix_t sb[$];
   int vectors = 0, miscompares = 0, issued = 0, done_cnt = 0;

   // Score whatever the DUT presents now; a pixel counts as issued when
   // it is shown with stall low (it is taken on the next rising edge).
   task automatic score();
      pix_t got, exp;
      if (frame_done) done_cnt++;
      if (!no_op && !stall) begin
         issued++;
         vectors++;
         got = {c1, c2, pix_col, pix_row};
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL pixel_unexpected got c1=%h c2=%h col=%0d row=%0d, none expected",
                     c1, c2, pix_col, pix_row);
         end else begin
            exp = sb.pop_front();
            if (got !== exp || x !== 16'h0 || y !== 16'h0 || div !== 8'h0) begin
               miscompares++;
               $display("FAIL pixel got c1=%h c2=%h col=%0d row=%0d x=%h y=%h div=%h exp c1=%h c2=%h col=%0d row=%0d seeds 0",
                        c1, c2, pix_col, pix_row, x, y, div, exp.c1, exp.c2, exp.col, exp.row);
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge Clk);
      score();
   endtask

   task automatic push_frame();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 4; c++) begin
            pix_t p;
            p.c1  = 16'hE000 + 16'(c * 256);
            p.c2  = 16'h1400 - 16'(r * 512);
            p.col = 10'(c);
            p.row = 9'(r);
            sb.push_back(p);
         end
   endtask

   task automatic run_to_done(input bit start_on_done, output int cyc, output int bub);
      cyc = 0;
      bub = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         cyc++;
         if (busy && no_op) bub++;
         if (frame_done) begin
            vectors++;
            if (busy !== 1'b0 || no_op !== 1'b1 || c1 !== 16'hE000 || c2 !== 16'h1400 ||
                pix_col !== 10'd0 || pix_row !== 9'd0) begin
               miscompares++;
               $display("FAIL done_state got busy=%b no_op=%b c1=%h c2=%h col=%0d row=%0d exp 0 1 e000 1400 0 0",
                        busy, no_op, c1, c2, pix_col, pix_row);
            end
            if (start_on_done) begin
               start = 1'b1;
               tick();
               start = 1'b0;
            end
            return;
         end
      end
      vectors++;
      miscompares++;
      $display("FAIL done_timeout no frame_done within 200 cycles");
   endtask

   task automatic check_frame_totals(input string name, input int exp_done);
      vectors++;
      if (issued !== 12 || done_cnt !== exp_done || sb.size() !== 0) begin
         miscompares++;
         $display("FAIL %s_totals got issued=%0d done=%0d left=%0d exp 12 %0d 0",
                  name, issued, done_cnt, sb.size(), exp_done);
      end
   endtask

   task automatic test_reset();
      #1 Reset = 1'b1;
      #2;
      vectors++;
      if (no_op !== 1'b1 || c1 !== 16'hE000 || c2 !== 16'h1400 || busy !== 1'b0 ||
          frame_done !== 1'b0 || pix_col !== 10'd0 || pix_row !== 9'd0 ||
          x !== 16'h0 || y !== 16'h0 || div !== 8'h0) begin
         miscompares++;
         $display("FAIL reset_values got no_op=%b c1=%h c2=%h busy=%b done=%b col=%0d row=%0d",
                  no_op, c1, c2, busy, frame_done, pix_col, pix_row);
      end
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      tick();
      vectors++;
      if (no_op !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_hold got no_op=%b busy=%b exp 1 0", no_op, busy);
      end
   endtask

   task automatic test_small_frame();
      int cyc, bub;
      push_frame();
      issued = 0;
      done_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      vectors++;
      if (no_op !== 1'b0 || busy !== 1'b1 || c1 !== 16'hE000 || c2 !== 16'h1400) begin
         miscompares++;
         $display("FAIL start_latency got no_op=%b busy=%b c1=%h c2=%h exp 0 1 e000 1400",
                  no_op, busy, c1, c2);
      end
      run_to_done(1'b0, cyc, bub);
      vectors++;
      if (cyc !== 17 || bub !== 5) begin
         miscompares++;
         $display("FAIL frame_timing got done_at=%0d bubbles=%0d exp 17 5", cyc, bub);
      end
      check_frame_totals("small", 1);
      tick();
      vectors++;
      if (frame_done !== 1'b0 || no_op !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL done_pulse got done=%b no_op=%b busy=%b exp 0 1 0", frame_done, no_op, busy);
      end
   endtask

   task automatic test_stall();
      int cyc, bub;
      push_frame();
      issued = 0;
      done_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      @(negedge Clk);
      stall = 1'b1;
      score();
      vectors++;
      if (pix_col !== 10'd2 || pix_row !== 9'd1) begin
         miscompares++;
         $display("FAIL stall_pos got col=%0d row=%0d exp 2 1", pix_col, pix_row);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         score();
         vectors++;
         if (c1 !== 16'hE200 || c2 !== 16'h1200 || pix_col !== 10'd2 || pix_row !== 9'd1 || no_op !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold got c1=%h c2=%h col=%0d row=%0d no_op=%b exp e200 1200 2 1 0",
                     c1, c2, pix_col, pix_row, no_op);
         end
      end
      stall = 1'b0;
      score();
      tick();
      vectors++;
      if (c1 !== 16'hE300 || pix_col !== 10'd3 || pix_row !== 9'd1) begin
         miscompares++;
         $display("FAIL stall_release got c1=%h col=%0d row=%0d exp e300 3 1", c1, pix_col, pix_row);
      end
      run_to_done(1'b0, cyc, bub);
      check_frame_totals("stall", 1);
   endtask

   task automatic test_start_stalled();
      int cyc, bub;
      push_frame();
      issued = 0;
      done_cnt = 0;
      @(negedge Clk);
      stall = 1'b1;
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (no_op !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stalled_start_hold got no_op=%b busy=%b exp 1 0", no_op, busy);
         end
         @(negedge Clk);
      end
      stall = 1'b0;
      tick();
      vectors++;
      if (no_op !== 1'b0 || pix_col !== 10'd0 || pix_row !== 9'd0) begin
         miscompares++;
         $display("FAIL stalled_start_issue got no_op=%b col=%0d row=%0d exp 0 0 0", no_op, pix_col, pix_row);
      end
      run_to_done(1'b0, cyc, bub);
      check_frame_totals("stalled_start", 1);
   endtask

   task automatic test_start_ignored();
      int cyc, bub;
      push_frame();
      issued = 0;
      done_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      run_to_done(1'b1, cyc, bub);
      for (int i = 0; i < 8; i++) begin
         tick();
         vectors++;
         if (busy !== 1'b0 || no_op !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_after_done got busy=%b no_op=%b exp 0 1", busy, no_op);
         end
      end
      check_frame_totals("start_ignored", 1);
   endtask

   task automatic test_reset_mid();
      int cyc, bub;
      push_frame();
      issued = 0;
      done_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      vectors++;
      if (issued !== 7) begin
         miscompares++;
         $display("FAIL pre_reset_count got %0d exp 7", issued);
      end
      @(posedge Clk);
      #2 Reset = 1'b1;
      #1;
      vectors++;
      if (no_op !== 1'b1 || busy !== 1'b0 || c1 !== 16'hE000 || c2 !== 16'h1400 ||
          pix_col !== 10'd0 || pix_row !== 9'd0 || frame_done !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset got no_op=%b busy=%b c1=%h c2=%h col=%0d row=%0d done=%b",
                  no_op, busy, c1, c2, pix_col, pix_row, frame_done);
      end
      @(negedge Clk);
      Reset = 1'b0;
      sb.delete();
      for (int i = 0; i < 20; i++) tick();
      vectors++;
      if (done_cnt !== 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abandoned_frame got done=%0d busy=%b exp 0 0", done_cnt, busy);
      end
      push_frame();
      issued = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      vectors++;
      if (no_op !== 1'b0 || c1 !== 16'hE000 || pix_col !== 10'd0 || pix_row !== 9'd0) begin
         miscompares++;
         $display("FAIL restart_first got no_op=%b c1=%h col=%0d row=%0d exp 0 e000 0 0",
                  no_op, c1, pix_col, pix_row);
      end
      run_to_done(1'b0, cyc, bub);
      check_frame_totals("restart", 1);
   endtask

   task automatic test_wrap();
      logic [15:0] tbl [4];
      tbl = '{16'h7F00, 16'h8000, 16'h8100, 16'h8200};
      @(negedge Clk);
      start_w = 1'b1;
      @(negedge Clk);
      start_w = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge Clk);
         vectors++;
         if (w_c1 !== tbl[i] || w_c2 !== 16'h1400 || w_no_op !== 1'b0 || w_busy !== 1'b1 ||
             w_pix_col !== 10'(i) || w_pix_row !== 9'd0 || w_frame_done !== 1'b0 ||
             w_x !== 16'h0 || w_y !== 16'h0 || w_div !== 8'h0) begin
            miscompares++;
            $display("FAIL wrap_c1 col %0d got c1=%h c2=%h no_op=%b col=%0d exp c1=%h c2=1400 no_op=0",
                     i, w_c1, w_c2, w_no_op, w_pix_col, tbl[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_small_frame();
      test_stall();
      test_start_stalled();
      test_start_ignored();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
